// File: rtl/xor_vector_sequencer.sv
// Clocked stimulus/response sequencer for small combinational datapaths.
// Plays back a loadable vector table and reports a pass/fail summary.
module xor_vector_sequencer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned IN_W   = 2,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [IN_W+OUT_W-1:0] wr_data,
  input  logic                start,
  input  logic [ADDR_W:0]     num_vec,
  output logic [IN_W-1:0]     dut_in,
  input  logic [OUT_W-1:0]    dut_out,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDR_W:0]     err_count,
  output logic [ADDR_W-1:0]   fail_addr
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned CNT_W = $clog2(SETTLE + 1);
  localparam int unsigned EW    = IN_W + OUT_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state;
  logic [EW-1:0]       table_mem [DEPTH];
  logic [CW-1:0]       count;
  logic [ADDR_W-1:0]   idx;
  logic [OUT_W-1:0]    exp_reg;
  logic [CNT_W-1:0]    cnt;
  logic [CW-1:0]       num_clamped;
  logic [EW-1:0]       cur_entry;
  logic                last_vec;

  always_comb begin
    num_clamped = num_vec;
    if (num_vec > CW'(DEPTH))
      num_clamped = CW'(DEPTH);
    cur_entry = table_mem[idx];
    last_vec  = ({1'b0, idx} == (count - CW'(1)));
  end

  // Table survives reset so a run can be repeated after an abort.
  always_ff @(posedge clk) begin
    if (wr_en && !busy)
      table_mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dut_in    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
      count     <= '0;
      idx       <= '0;
      exp_reg   <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            err_count <= '0;
            if (num_clamped == '0) begin
              done <= 1'b1;
              pass <= 1'b1;
            end else begin
              count     <= num_clamped;
              idx       <= '0;
              fail_addr <= '0;
              done      <= 1'b0;
              pass      <= 1'b0;
              busy      <= 1'b1;
              state     <= S_APPLY;
            end
          end
        end
        S_APPLY: begin
          dut_in  <= cur_entry[EW-1:OUT_W];
          exp_reg <= cur_entry[OUT_W-1:0];
          cnt     <= CNT_W'(SETTLE);
          state   <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= S_CHECK;
        end
        S_CHECK: begin
          if (dut_out != exp_reg) begin
            err_count <= err_count + CW'(1);
            // err_count still zero means this is the first miss of the run.
            if (err_count == '0)
              fail_addr <= idx;
          end
          if (last_vec) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + ADDR_W'(1);
            state <= S_APPLY;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_vector_sequencer.sv
// Directed bench for xor_vector_sequencer driving an XOR datapath.
// Two instances cover SETTLE=1 and SETTLE=3 timing.
module tb_xor_vector_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [2:0] wr_data;
  logic       start1, start3;
  logic [2:0] num_vec;

  logic [1:0] dut_in1, dut_in3;
  logic       dut_out1, dut_out3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [2:0] err1, err3;
  logic [1:0] fail1, fail3;

  int total = 0;
  int bad   = 0;
  int cyc;

  always #5 clk = ~clk;

  assign dut_out1 = dut_in1[1] ^ dut_in1[0];
  assign dut_out3 = dut_in3[1] ^ dut_in3[0];

  xor_vector_sequencer #(.DEPTH(4), .ADDR_W(2), .IN_W(2), .OUT_W(1), .SETTLE(1)) u_seq1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start1), .num_vec(num_vec), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_addr(fail1)
  );

  xor_vector_sequencer #(.DEPTH(4), .ADDR_W(2), .IN_W(2), .OUT_W(1), .SETTLE(3)) u_seq3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start3), .num_vec(num_vec), .dut_in(dut_in3), .dut_out(dut_out3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_addr(fail3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_good();
    wr(2'd0, 3'b000);
    wr(2'd1, 3'b011);
    wr(2'd2, 3'b101);
    wr(2'd3, 3'b110);
  endtask

  // Counts edges after the start edge until done rises; a timeout is a failure.
  task automatic wait_done(input bit sel3, input int from, output int n);
    n = from;
    while (!(sel3 ? done3 : done1) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      bad++;
      $display("FAIL wait_done: got timeout expected done");
    end
  endtask

  task automatic run(input bit sel3, input logic [2:0] nv, output int n);
    if (sel3) start3 = 1'b1; else start1 = 1'b1;
    num_vec = nv;
    tick();
    start1 = 1'b0; start3 = 1'b0;
    wait_done(sel3, 0, n);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dut_in"}, dut_in1, 0);
    check({tag, "_busy"},   busy1,   0);
    check({tag, "_done"},   done1,   0);
    check({tag, "_pass"},   pass1,   0);
    check({tag, "_err"},    err1,    0);
    check({tag, "_fail"},   fail1,   0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start1 = 1'b0; start3 = 1'b0; num_vec = '0;
    tick(); tick();
    reset = 1'b0;
    check_zero("rst");

    // Pass run with per-vector dut_in timing
    load_good();
    start1 = 1'b1; num_vec = 3'd4;
    tick();
    start1 = 1'b0;
    check("pass_busy0", busy1, 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("pass_dut_in%0d", k), dut_in1, k);
      tick(); tick();
    end
    check("pass_done_early", done1, 0);
    tick();
    check("pass_done13", done1, 1);
    check("pass_busy", busy1, 0);
    check("pass_pass", pass1, 1);
    check("pass_err", err1, 0);
    check("pass_hold", dut_in1, 3);

    // Single fault at entry 2
    wr(2'd2, 3'b100);
    run(1'b0, 3'd4, cyc);
    check("sf_cyc", cyc, 13);
    check("sf_pass", pass1, 0);
    check("sf_err", err1, 1);
    check("sf_fail", fail1, 2);

    // Every expected bit inverted, SETTLE=3
    wr(2'd0, 3'b001);
    wr(2'd1, 3'b010);
    wr(2'd2, 3'b100);
    wr(2'd3, 3'b111);
    run(1'b1, 3'd4, cyc);
    check("mf_cyc", cyc, 21);
    check("mf_err", err3, 4);
    check("mf_fail", fail3, 0);
    check("mf_pass", pass3, 0);

    // Zero count: immediate done, err cleared, dut_in untouched
    load_good();
    start1 = 1'b1; num_vec = 3'd0;
    tick();
    start1 = 1'b0;
    check("z_done", done1, 1);
    check("z_pass", pass1, 1);
    check("z_err", err1, 0);
    check("z_busy", busy1, 0);
    check("z_dut_in", dut_in1, 3);

    // Clamp 7 -> 4 vectors
    run(1'b0, 3'd7, cyc);
    check("cl_cyc", cyc, 13);
    check("cl_pass", pass1, 1);

    // start and wr_en during a run are ignored
    start1 = 1'b1; num_vec = 3'd4;
    tick();
    start1 = 1'b0;
    tick(); tick();
    start1 = 1'b1; num_vec = 3'd1;
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 3'b111;
    tick();
    start1 = 1'b0; wr_en = 1'b0;
    wait_done(1'b0, 3, cyc);
    check("ig_cyc", cyc, 13);
    check("ig_pass", pass1, 1);
    tick(); tick(); tick();
    check("ig_once", busy1, 0);
    run(1'b0, 3'd4, cyc);
    check("ig_rerun_pass", pass1, 1);
    check("ig_rerun_err", err1, 0);

    // Reset while vector 2 waits
    start1 = 1'b1; num_vec = 3'd4;
    tick();
    start1 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("mr_busy", busy1, 1);
    check("mr_dut_in", dut_in1, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("mr");
    run(1'b0, 3'd4, cyc);
    check("mr_cyc", cyc, 13);
    check("mr_pass", pass1, 1);
    check("mr_err", err1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
